btn_conditioner: RTL and testbench

Input conditioner that turns a raw, asynchronous, bouncy push-button into clean, clock-synchronous signals for the timer-switch logic. It synchronizes the input and debounces it with a small state machine. It emits a stable level, a one-cycle press pulse and a one-cycle release pulse. Optionally it also emits a one-cycle long-press pulse. It sits between the external pin and any consumer of `btn_ext`-style press events.

---
 rtl/btn_conditioner.sv | 145 ++++++++++++++
 tb/tb_btn_conditioner.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// Push-button conditioner: two-flop synchronizer, debounce FSM, press/release pulses.
// Optional long-press pulse is built only when BTN_LONG_PRESS_EN is defined.
module btn_conditioner #(
    parameter int STABLE_CYCLES = 3,
    parameter int LONG_CYCLES   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);

    localparam int CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255 || LONG_CYCLES < 1 || LONG_CYCLES > 65535) begin : g_param_check
        $error("btn_conditioner: parameter out of range");
    end

    typedef enum logic [1:0] {IDLE, ARMING, HELD, RELEASING} state_t;

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next;
    logic          press_next, release_next;
    logic          sync1, sync2;

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            btn_level   <= (state_next == HELD) || (state_next == RELEASING);
            btn_press   <= press_next;
            btn_release <= release_next;
        end
    end

    // Any sample disagreeing with the pending level drops back to the stable state.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        press_next   = 1'b0;
        release_next = 1'b0;
        case (state)
            IDLE: begin
                if (sync2) begin
                    if (STABLE_CYCLES == 1) begin
                        state_next = HELD;
                        cnt_next   = '0;
                        press_next = 1'b1;
                    end else begin
                        state_next = ARMING;
                        cnt_next   = CW'(1);
                    end
                end
            end
            ARMING: begin
                if (!sync2) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = HELD;
                    cnt_next   = '0;
                    press_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            HELD: begin
                if (!sync2) begin
                    if (STABLE_CYCLES == 1) begin
                        state_next   = IDLE;
                        cnt_next     = '0;
                        release_next = 1'b1;
                    end else begin
                        state_next = RELEASING;
                        cnt_next   = CW'(1);
                    end
                end
            end
            RELEASING: begin
                if (sync2) begin
                    state_next = HELD;
                    cnt_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next   = IDLE;
                    cnt_next     = '0;
                    release_next = 1'b1;
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

`ifdef BTN_LONG_PRESS_EN
    localparam logic [15:0] LONG_TARGET = 16'(LONG_CYCLES);

    logic [15:0] hold_cnt;
    logic        hold_inc;

    assign hold_inc = ((state == HELD) || (state == RELEASING)) && (hold_cnt != 16'hFFFF);

    // Firing only on the increment that lands on the target gives one pulse per press, even when saturated.
    always_ff @(posedge clock) begin
        if (reset) begin
            hold_cnt <= '0;
            btn_long <= 1'b0;
        end else if (press_next) begin
            hold_cnt <= '0;
            btn_long <= 1'b0;
        end else begin
            if (hold_inc) begin
                hold_cnt <= hold_cnt + 16'd1;
            end
            btn_long <= hold_inc && ((hold_cnt + 16'd1) == LONG_TARGET) && !release_next;
        end
    end
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: directed button waveforms, expected pulses queued
// with their edge numbers, a negedge monitor pops and compares every pulse the DUT emits.
module tb_btn_conditioner;

    localparam int KPRESS   = 0;
    localparam int KRELEASE = 1;
    localparam int KLONG    = 2;

    typedef struct {
        int kind;
        int cyc;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic btn_raw = 1'b1;
    logic btn_level, btn_press, btn_release, btn_long;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];

    btn_conditioner dut (
        .clock      (clock),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_long   (btn_long)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    function automatic string kindName(input int k);
        case (k)
            KPRESS:   return "press";
            KRELEASE: return "release";
            default:  return "long";
        endcase
    endfunction

    task automatic pushExpect(input int kind, input int atCyc);
        exp_t e;
        e.kind = kind;
        e.cyc  = atCyc;
        expq.push_back(e);
    endtask

    task automatic waitUntil(input int n);
        while (cyc < n) @(negedge clock);
    endtask

    task automatic applyStimulus(input logic val, input int atCyc);
        waitUntil(atCyc);
        btn_raw = val;
    endtask

    // obs = {level, long, release, press}
    task automatic checkOutput(input string name, input int atCyc, input logic [3:0] mask, input logic [3:0] expv);
        logic [3:0] obs;
        waitUntil(atCyc);
        obs = {btn_level, btn_long, btn_release, btn_press};
        checks++;
        if ((obs & mask) !== expv) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got %b required %b (mask %b)", name, cyc, obs & mask, expv, mask);
        end
    endtask

    // Monitor: every pulse must match the head of the expectation queue.
    always @(negedge clock) begin
        logic [2:0] pulses;
        exp_t       e;
        if (cyc >= 1) begin
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                e = expq.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL missed_%s: got nothing by cycle %0d required pulse at cycle %0d", kindName(e.kind), cyc, e.cyc);
            end
            pulses = {btn_long, btn_release, btn_press};
            for (int k = 0; k < 3; k++) begin
                if (pulses[k]) begin
                    checks++;
                    if (expq.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL unexpected_%s: got pulse at cycle %0d required none", kindName(k), cyc);
                    end else begin
                        e = expq.pop_front();
                        if (e.kind != k || e.cyc != cyc) begin
                            errors++;
                            $display("[TB] FAIL pulse_%s: got %s at cycle %0d required %s at cycle %0d",
                                     kindName(e.kind), kindName(k), cyc, kindName(e.kind), e.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        // Reset held two cycles with the button already pressed.
        pushExpect(KPRESS, 7);
        checkOutput("reset_c1", 1, 4'b1111, 4'b0000);
        checkOutput("reset_c2", 2, 4'b1111, 4'b0000);
        reset = 1'b0;
        checkOutput("post_reset_lvl_lo", 6, 4'b1000, 4'b0000);
        checkOutput("post_reset_lvl_hi", 7, 4'b1000, 4'b1000);
        pushExpect(KRELEASE, 14);
        applyStimulus(1'b0, 9);
        checkOutput("rel1_lvl_hi", 13, 4'b1000, 4'b1000);
        checkOutput("rel1_lvl_lo", 14, 4'b1000, 4'b0000);

        // Clean press held 20 cycles.
        pushExpect(KPRESS, 24);
`ifdef BTN_LONG_PRESS_EN
        pushExpect(KLONG, 32);
`endif
        pushExpect(KRELEASE, 44);
        applyStimulus(1'b1, 19);
        checkOutput("clean_lvl_lo", 23, 4'b1000, 4'b0000);
        checkOutput("clean_lvl_hi", 24, 4'b1000, 4'b1000);
        applyStimulus(1'b0, 39);
        checkOutput("clean_rel_lvl_hi", 43, 4'b1000, 4'b1000);
        checkOutput("clean_rel_lvl_lo", 44, 4'b1000, 4'b0000);

        // Bounce 1,0,1,0 while idle.
        applyStimulus(1'b1, 49);
        applyStimulus(1'b0, 50);
        applyStimulus(1'b1, 51);
        applyStimulus(1'b0, 52);
        checkOutput("bounce_lvl_a", 53, 4'b1111, 4'b0000);
        checkOutput("bounce_lvl_b", 56, 4'b1111, 4'b0000);

        // Press with two single-cycle dropouts while held.
        pushExpect(KPRESS, 65);
`ifdef BTN_LONG_PRESS_EN
        pushExpect(KLONG, 73);
`endif
        pushExpect(KRELEASE, 84);
        applyStimulus(1'b1, 60);
        applyStimulus(1'b0, 69);
        applyStimulus(1'b1, 70);
        checkOutput("dropout_lvl_a", 72, 4'b1000, 4'b1000);
        checkOutput("dropout_lvl_b", 73, 4'b1000, 4'b1000);
        applyStimulus(1'b0, 74);
        applyStimulus(1'b1, 75);
        checkOutput("dropout_lvl_c", 77, 4'b1000, 4'b1000);
        applyStimulus(1'b0, 79);

        // 15-cycle hold.
        pushExpect(KPRESS, 94);
`ifdef BTN_LONG_PRESS_EN
        pushExpect(KLONG, 102);
`endif
        pushExpect(KRELEASE, 109);
        applyStimulus(1'b1, 89);
        checkOutput("long_lvl_hi", 102, 4'b1000, 4'b1000);
        applyStimulus(1'b0, 104);
        checkOutput("long_lvl_lo", 109, 4'b1000, 4'b0000);

        // 5-cycle hold: never long.
        pushExpect(KPRESS, 124);
        pushExpect(KRELEASE, 129);
        applyStimulus(1'b1, 119);
        applyStimulus(1'b0, 124);
        checkOutput("short_lvl_lo", 129, 4'b1000, 4'b0000);

        // Reset while held, button stays down, then a fresh press.
        pushExpect(KPRESS, 144);
        applyStimulus(1'b1, 139);
        checkOutput("midhold_lvl_hi", 144, 4'b1000, 4'b1000);
        waitUntil(150);
        reset = 1'b1;
        checkOutput("midhold_reset", 151, 4'b1111, 4'b0000);
        reset = 1'b0;
        pushExpect(KPRESS, 156);
        pushExpect(KRELEASE, 162);
        checkOutput("redebounce_lvl_lo", 155, 4'b1000, 4'b0000);
        checkOutput("redebounce_lvl_hi", 156, 4'b1000, 4'b1000);
        applyStimulus(1'b0, 157);
        checkOutput("final_lvl_lo", 162, 4'b1000, 4'b0000);

        waitUntil(180);
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d pending expectations required 0", expq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
